// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4x1 mux: steps sel through channels 0..3,
// dwells DWELL cycles on each, samples f_in, and publishes the 4-bit result.
`timescale 1ns/1ps
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic       f_in,
  output logic [1:0] sel,
  output logic [3:0] data_out,
  output logic       valid,
  output logic       busy
);

  localparam logic       S_IDLE = 1'b0;
  localparam logic       S_SCAN = 1'b1;
  localparam logic [3:0] LAST   = 4'(DWELL - 1);

  logic       r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic [2:0] r_sh;
  logic [3:0] r_data;
  logic       r_valid;
  logic       w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_sel   <= 2'd0;
      r_sh    <= 3'd0;
      r_data  <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          r_sel <= 2'd0;
          // a coincident abort vetoes the start
          if (start && !abort) r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_sel   <= 2'd0;
            r_sh    <= 3'd0;
          end else if (!w_last) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_cnt <= 4'd0;
            if (r_sel != 2'd3) begin
              r_sh[r_sel] <= f_in;
              r_sel       <= r_sel + 2'd1;
            end else begin
              r_data  <= {f_in, r_sh};
              r_valid <= 1'b1;
              r_sel   <= 2'd0;
              r_sh    <= 3'd0;
              r_state <= cont ? S_SCAN : S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel      = r_sel;
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = (r_state == S_SCAN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL 2, 3, 1) share stimulus; directed
// scenarios use fixed expectations, the random phase uses a timeline model.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

  logic       clk, rst_n, start, abort, cont;
  logic [3:0] mux_in;
  logic       f_in  [3];
  logic [1:0] sel   [3];
  logic [3:0] dout  [3];
  logic       valid [3];
  logic       busy  [3];
  int         n_chk, n_pass;

  mux_scan_ctrl #(.DWELL(2)) u_d2 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .f_in(f_in[0]), .sel(sel[0]), .data_out(dout[0]), .valid(valid[0]), .busy(busy[0]));
  mux_scan_ctrl #(.DWELL(3)) u_d3 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .f_in(f_in[1]), .sel(sel[1]), .data_out(dout[1]), .valid(valid[1]), .busy(busy[1]));
  mux_scan_ctrl #(.DWELL(1)) u_d1 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .f_in(f_in[2]), .sel(sel[2]), .data_out(dout[2]), .valid(valid[2]), .busy(busy[2]));

  // each instance drives its own model of the downstream 4x1 mux
  assign f_in[0] = mux_in[sel[0]];
  assign f_in[1] = mux_in[sel[1]];
  assign f_in[2] = mux_in[sel[2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dw(int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
  endfunction

  // Reference: a scan is a timeline of 4*D edges after start; channel e/D is
  // sampled on the last edge of its dwell window.
  typedef struct packed {
    logic       busy;
    logic [5:0] e;
    logic [3:0] bits;
    logic [3:0] data;
    logic       valid;
  } model_t;

  model_t m [3];

  function automatic model_t step(model_t cur, int d, logic st, logic ab, logic co, logic [3:0] mi);
    model_t n;
    int     ch, e;
    n       = cur;
    n.valid = 1'b0;
    e       = int'(cur.e);
    if (!cur.busy) begin
      if (st && !ab) begin n.busy = 1'b1; n.e = 6'd0; end
    end else if (ab) begin
      n.busy = 1'b0; n.e = 6'd0;
    end else begin
      ch = e / d;
      if (e % d == d - 1) n.bits[ch] = mi[ch];
      if (e == 4 * d - 1) begin
        n.data = n.bits; n.valid = 1'b1; n.busy = co; n.e = 6'd0;
      end else begin
        n.e = cur.e + 6'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= step(m[i], dw(i), start, abort, cont, mux_in);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0; mux_in = 4'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({sel[i], dout[i], valid[i], busy[i]} !== 8'd0)
        $display("FAIL reset_state dut%0d: got sel=%0d data=%b valid=%b busy=%b, want all zero", i, sel[i], dout[i], valid[i], busy[i]);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({sel[0], dout[0], valid[0], busy[0]} !== 8'd0)
      $display("FAIL reset_release: got sel=%0d data=%b valid=%b busy=%b, want all zero", sel[0], dout[0], valid[0], busy[0]);
    else n_pass++;
  endtask

  task automatic test_single();
    mux_in = 4'b0101; start = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk); start = 1'b0;
      n_chk++;
      if (sel[0] !== 2'(j / 2) || busy[0] !== 1'b1 || valid[0] !== 1'b0)
        $display("FAIL single_seq cyc%0d: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0", j, sel[0], busy[0], valid[0], j / 2);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (valid[0] !== 1'b1 || dout[0] !== 4'b0101 || busy[0] !== 1'b0 || sel[0] !== 2'd0)
      $display("FAIL single_done: valid=%b data=%b busy=%b sel=%0d, want 1 0101 0 0", valid[0], dout[0], busy[0], sel[0]);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (valid[0] !== 1'b0) $display("FAIL single_pulse_width: valid=%b, want 0", valid[0]);
    else n_pass++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_abort();
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_chk++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0)
      $display("FAIL idle_start_abort: busy=%b%b, want 00", busy[0], busy[1]);
    else n_pass++;
    mux_in = 4'b1111; start = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk); start = 1'b0;
      n_chk++;
      if (sel[1] !== 2'(j / 3)) $display("FAIL abort_seq cyc%0d: sel=%0d, want %0d", j, sel[1], j / 3);
      else n_pass++;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_chk++;
    if (busy[1] !== 1'b0 || sel[1] !== 2'd0 || valid[1] !== 1'b0 || dout[1] !== 4'b0101)
      $display("FAIL abort_now: busy=%b sel=%0d valid=%b data=%b, want 0 0 0 0101", busy[1], sel[1], valid[1], dout[1]);
    else n_pass++;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      n_chk++;
      if (valid[1] !== 1'b0 || busy[1] !== 1'b0 || dout[1] !== 4'b0101)
        $display("FAIL abort_after cyc%0d: valid=%b busy=%b data=%b, want 0 0 0101", j, valid[1], busy[1], dout[1]);
      else n_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    mux_in = 4'b0101; start = 1'b1;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      n_chk++;
      if (valid[0] !== (j == 8) || busy[0] !== (j < 8))
        $display("FAIL restart_ignored cyc%0d: valid=%b busy=%b, want %b %b", j, valid[0], busy[0], j == 8, j < 8);
      else n_pass++;
      start = (j == 2);
    end
  endtask

  task automatic test_cont();
    logic vexp;
    mux_in = 4'b0011; cont = 1'b1; start = 1'b1;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk); start = 1'b0;
      vexp = (j > 0 && j % 8 == 0 && j <= 32);
      n_chk++;
      if (valid[0] !== vexp || busy[0] !== (j < 32) || (vexp && dout[0] !== 4'b0011))
        $display("FAIL cont cyc%0d: valid=%b busy=%b data=%b, want valid=%b busy=%b data=0011", j, valid[0], busy[0], dout[0], vexp, j < 32);
      else n_pass++;
      if (j == 28) cont = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    mux_in = 4'b1111; start = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk); start = 1'b0;
      n_chk++;
      if (sel[0] !== 2'(j / 2)) $display("FAIL rstmid_seq cyc%0d: sel=%0d, want %0d", j, sel[0], j / 2);
      else n_pass++;
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sel[0], dout[0], valid[0], busy[0]} !== 8'd0)
      $display("FAIL rstmid_async: sel=%0d data=%b valid=%b busy=%b, want all zero", sel[0], dout[0], valid[0], busy[0]);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_chk++;
      if (busy[0] !== 1'b0 || valid[0] !== 1'b0 || sel[0] !== 2'd0 || dout[0] !== 4'd0)
        $display("FAIL rstmid_after cyc%0d: busy=%b valid=%b sel=%0d data=%b, want 0 0 0 0000", j, busy[0], valid[0], sel[0], dout[0]);
      else n_pass++;
    end
  endtask

  task automatic test_dwell1();
    mux_in = 4'b1110; start = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); start = 1'b0;
      n_chk++;
      if (sel[2] !== 2'(j) || busy[2] !== 1'b1) $display("FAIL dwell1_seq cyc%0d: sel=%0d busy=%b, want %0d 1", j, sel[2], busy[2], j);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (valid[2] !== 1'b1 || dout[2] !== 4'b1110) $display("FAIL dwell1_done: valid=%b data=%b, want 1 1110", valid[2], dout[2]);
    else n_pass++;
    repeat (10) @(negedge clk);
    mux_in = 4'b0001; start = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_chk++;
    if (valid[2] !== 1'b0 || dout[2] !== 4'b1110 || busy[2] !== 1'b0)
      $display("FAIL dwell1_abort_complete: valid=%b data=%b busy=%b, want 0 1110 0", valid[2], dout[2], busy[2]);
    else n_pass++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    logic [1:0] esel;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        esel = m[i].busy ? 2'(int'(m[i].e) / dw(i)) : 2'd0;
        exp  = {esel, m[i].data, m[i].valid, m[i].busy};
        got  = {sel[i], dout[i], valid[i], busy[i]};
        n_chk++;
        if (got !== exp) $display("FAIL random cyc%0d dut%0d: {sel,data,valid,busy}=%b, want %b", c, i, got, exp);
        else n_pass++;
      end
      start  = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) cont = ~cont;
      mux_in = 4'($urandom);
    end
    start = 1'b0; abort = 1'b0; cont = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_single();
    test_abort();
    test_restart_ignored();
    test_cont();
    test_reset_mid();
    test_dwell1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, default 2, number of clock cycles select is held on each channel before sampling; legal range 1..15.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request one scan of all four channels; sampled on rising clk.
REQ-005 Port: abort  input  1  synchronous cancel of a scan in progress.
REQ-006 Port: cont  input  1  continuous mode; when high, a new scan begins immediately after each completed scan.
REQ-007 Port: f_in  input  1  output F of the downstream 4x1 mux.
REQ-008 Port: sel  output  2  select S driven to the 4x1 mux; registered.
REQ-009 Port: data_out  output  4  last completed scan; data_out[i] = f_in sampled while sel==i.
REQ-010 Port: valid  output  1  one-cycle pulse marking data_out updated.
REQ-011 Port: busy  output  1  high while a scan is in progress.

Function
REQ-012 The block SHALL implement two states: IDLE and SCAN, plus a 4-bit dwell counter cnt and a 3-bit shadow register sh[2:0].
REQ-013 In IDLE, sel SHALL be 0, busy 0, cnt 0; start=1 at a rising edge SHALL move to SCAN with sel=0, cnt=0.
REQ-014 In SCAN, busy SHALL be 1; each edge with cnt<DWELL-1 and abort=0 SHALL increment cnt, sel unchanged.
REQ-015 At an edge with cnt==DWELL-1 and sel<3 (abort=0), the block SHALL store f_in into sh[sel], increment sel, clear cnt.
REQ-016 At an edge with cnt==DWELL-1 and sel==3 (abort=0), the block SHALL load data_out <= {f_in, sh[2:0]} and set valid=1 for exactly the following cycle.
REQ-017 On that same completing edge, the block SHALL go to SCAN with sel=0, cnt=0 if cont=1, otherwise to IDLE with sel=0.
REQ-018 Latency: with start sampled at edge k, valid SHALL be high in the cycle after edge k+4*DWELL; back-to-back scans in cont mode SHALL produce valid every 4*DWELL cycles.
REQ-019 start while in SCAN SHALL be ignored (no restart, no queuing).
REQ-020 abort=1 in SCAN SHALL, at the next edge, return to IDLE, sel=0, cnt=0, sh cleared, no valid pulse, data_out unchanged; abort takes priority over a coincident completion.
REQ-021 abort=1 in IDLE SHALL have no effect; simultaneous start=1 and abort=1 in IDLE SHALL remain in IDLE.
REQ-022 When cont falls during a scan, the current scan SHALL complete normally and the block SHALL then return to IDLE.
REQ-023 With DWELL=1, every SCAN edge SHALL sample and advance sel (cnt stays 0).
REQ-024 f_in SHALL be sampled only at the REQ-015/REQ-016 edges; changes at other times SHALL not affect data_out.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sel=2'b00, cnt=0, sh=0, data_out=4'b0000, valid=0, busy=0, regardless of clk.
REQ-026 Reset asserted mid-scan SHALL discard the partial scan; the first action after release SHALL require a new start (or cont with start).
REQ-027 Outputs SHALL hold reset values until the first rising edge after rst_n returns high.

Verification
REQ-028 DWELL=2, mux inputs A,B,C,D=1,0,1,0, pulse start -> sel 0,0,1,1,2,2,3,3; valid pulse 8 cycles after start edge; data_out=4'b0101.
REQ-029 DWELL=2, A,B,C,D=1,1,0,0, cont=1 held -> valid every 8 cycles, data_out=4'b0011 each time; drop cont -> one more valid, then IDLE, busy=0.
REQ-030 DWELL=3, abort pulsed while sel==2 -> next cycle IDLE, busy=0, sel=0, no valid, data_out keeps previous value 4'b0101.
REQ-031 DWELL=2, start re-pulsed at sel==1 -> ignored; single valid at original 8-cycle point.
REQ-032 rst_n low for 3 cycles mid-scan (sel==2) -> sel=0, data_out=0, valid=0, busy=0 asynchronously; no valid after release until new start.
REQ-033 DWELL=1, A,B,C,D=0,1,1,1 -> sel steps every cycle, valid 4 cycles after start edge, data_out=4'b1110; abort coincident with completion -> no valid, data_out unchanged.
